// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neuron activation stage:
// default word format, Q-scaled PLAN sigmoid constants and FSM states.
package nn_fixed_pkg;

    localparam int DEF_N = 16;
    localparam int DEF_Q = 13;

    // (num / 2**den_log2) expressed with q fractional bits
    function automatic int q_scale(input int num, input int den_log2, input int q);
        return (num << q) >>> den_log2;
    endfunction

    localparam int ONE      = q_scale(1, 0, DEF_Q);   // 1.0
    localparam int HALF     = q_scale(1, 1, DEF_Q);   // 0.5
    localparam int C_0625   = q_scale(5, 3, DEF_Q);   // 0.625
    localparam int C_084375 = q_scale(27, 5, DEF_Q);  // 0.84375
    localparam int BP_1     = q_scale(1, 0, DEF_Q);   // 1.0
    localparam int BP_2375  = q_scale(19, 3, DEF_Q);  // 2.375
    localparam int BP_5     = q_scale(5, 0, DEF_Q);   // 5.0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } act_state_e;

endpackage

// File: rtl/pwl_sigmoid_core.sv
// Combinational PLAN sigmoid for one element: takes sign and |x|,
// returns y in [0, 1.0]. Arithmetic is done in 32 bits so breakpoints
// that exceed the N-bit range (e.g. 5.0 at Q=13) compare without wrapping.
module pwl_sigmoid_core
    import nn_fixed_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
) (
    input  logic [N-1:0] mag,
    input  logic         neg,
    output logic [N-1:0] y
);

    localparam int C_ONE   = (Q == DEF_Q) ? ONE      : q_scale(1, 0, Q);
    localparam int C_HALF  = (Q == DEF_Q) ? HALF     : q_scale(1, 1, Q);
    localparam int C_A     = (Q == DEF_Q) ? C_0625   : q_scale(5, 3, Q);
    localparam int C_B     = (Q == DEF_Q) ? C_084375 : q_scale(27, 5, Q);
    localparam int C_BP1   = (Q == DEF_Q) ? BP_1     : q_scale(1, 0, Q);
    localparam int C_BP2   = (Q == DEF_Q) ? BP_2375  : q_scale(19, 3, Q);
    localparam int C_BP5   = (Q == DEF_Q) ? BP_5     : q_scale(5, 0, Q);

    int a;
    int y_pos;
    int y_full;

    // Segment select on |x|, then mirror around 0.5 for negative inputs
    always_comb begin
        a = int'(mag);
        y_pos = C_ONE;
        if (a >= C_BP5) begin
            y_pos = C_ONE;
        end else if (a >= C_BP2) begin
            y_pos = (a >>> 5) + C_B;
        end else if (a >= C_BP1) begin
            y_pos = (a >>> 3) + C_A;
        end else begin
            y_pos = (a >>> 2) + C_HALF;
        end
        y_full = neg ? (C_ONE - y_pos) : y_pos;
        y = y_full[N-1:0];
    end

endmodule

// File: rtl/hidden_activation_pwl.sv
// Activation stage after the input->hidden layer. Captures a whole
// pre-activation vector, pushes one element per cycle through a 2-stage
// pipe (sign/|x| register, then activation and write-back) and holds the
// activated vector for the next layer.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_ready is high only in IDLE; out_valid is high only in HOLD
// and data_out does not change while out_valid is high.
module hidden_activation_pwl
    import nn_fixed_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int Q           = DEF_Q,
    parameter int NUM_NEURONS = 2,
    parameter int ACT_TYPE    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*NUM_NEURONS-1:0] data_in,
    output logic [N*NUM_NEURONS-1:0] data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    act_state_e       state_q, state_d;
    logic [N-1:0]     in_r  [NUM_NEURONS];
    logic [N-1:0]     out_r [NUM_NEURONS];
    logic [IDX_W-1:0] idx, s1_idx;
    logic             issue_done;
    logic             s1_valid, s1_neg;
    logic [N-1:0]     s1_mag;
    logic [N-1:0]     x_sel, mag_c, sig_y, act_y;
    logic             capture, last_write;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;
    assign capture    = in_valid && in_ready;
    assign last_write = s1_valid && (s1_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: capture starts a run, last write-back ends it, accept frees it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = RUN;
            RUN:     if (last_write) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Magnitude of the element being issued; the most negative value saturates
    always_comb begin
        x_sel = in_r[idx];
        mag_c = x_sel;
        if (x_sel[N-1]) begin
            if (x_sel == {1'b1, {(N-1){1'b0}}}) mag_c = {1'b0, {(N-1){1'b1}}};
            else                                mag_c = -x_sel;
        end
    end

    pwl_sigmoid_core #(.N(N), .Q(Q)) u_core (
        .mag (s1_mag),
        .neg (s1_neg),
        .y   (sig_y)
    );

    // ReLU reuses stage 1: a non-negative x equals its magnitude
    assign act_y = (ACT_TYPE == 1) ? (s1_neg ? '0 : s1_mag) : sig_y;

    // Input capture, issue counter and stage-1 pipe register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) in_r[i] <= '0;
            idx        <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s1_neg     <= 1'b0;
            s1_mag     <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (capture) begin
                for (int i = 0; i < NUM_NEURONS; i++) in_r[i] <= data_in[i*N +: N];
                idx        <= '0;
                issue_done <= 1'b0;
            end else if (state_q == RUN && !issue_done) begin
                s1_valid <= 1'b1;
                s1_idx   <= idx;
                s1_neg   <= x_sel[N-1];
                s1_mag   <= mag_c;
                if (idx == LAST_IDX) issue_done <= 1'b1;
                else                 idx <= idx + 1'b1;
            end
        end
    end

    // Stage 2: write activated element back into the output vector
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) out_r[i] <= '0;
        end else if (s1_valid && state_q == RUN) begin
            out_r[s1_idx] <= act_y;
        end
    end

    // Flatten output registers onto the vector port
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_NEURONS; i++) data_out[i*N +: N] = out_r[i];
    end

endmodule

// File: tb/tb_hidden_activation_pwl.sv
// Directed bench for hidden_activation_pwl: PLAN sigmoid instance plus a
// ReLU instance, hand-computed expected vectors, backpressure and reset.
`timescale 1ns/1ps
module tb_hidden_activation_pwl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] data_in = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] data_out;
    logic [1:0]  state_dbg;

    logic        r_in_valid = 1'b0, r_out_ready = 1'b0;
    logic [31:0] r_data_in = '0;
    logic        r_in_ready, r_out_valid, r_busy;
    logic [31:0] r_data_out;
    logic [1:0]  r_state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Clock
    always #5 clk = ~clk;

    hidden_activation_pwl #(.N(16), .Q(13), .NUM_NEURONS(2), .ACT_TYPE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .state_dbg(state_dbg)
    );

    hidden_activation_pwl #(.N(16), .Q(13), .NUM_NEURONS(2), .ACT_TYPE(1)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .data_in(r_data_in), .data_out(r_data_out), .out_valid(r_out_valid),
        .out_ready(r_out_ready), .busy(r_busy), .state_dbg(r_state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture a vector on the sigmoid instance and wait for out_valid
    task automatic send_vec(input string tag, input logic [31:0] v, output int lat);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        data_in  = v;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v, input logic [31:0] exp);
        int lat;
        send_vec(tag, v, lat);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, data_out, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, in_ready, 1'b1);
        check({tag, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_state", state_dbg, 2'd0);

        run_vec("t1_half", {16'h0000, 16'h1000}, {16'h1000, 16'h1400});
        run_vec("t2_pm1", {16'h2000, 16'hE000}, {16'h1800, 16'h0800});
        run_vec("t3_bp2375", {16'h4BFF, 16'h4C00}, {16'h1D7F, 16'h1D60});
        run_vec("t4_extreme", {16'h7FFF, 16'h8000}, {16'h1EFF, 16'h0101});

        // ReLU instance
        r_in_valid = 1'b1;
        r_data_in  = {16'h8000, 16'h3000};
        step();
        r_in_valid = 1'b0;
        lat = 0;
        while (!r_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("relu_latency", lat, 3);
        check("relu_data", r_data_out, {16'h0000, 16'h3000});
        r_out_ready = 1'b1;
        step();
        r_out_ready = 1'b0;
        check("relu_idle", r_in_ready, 1'b1);

        // Backpressure with in_valid toggling on fresh data
        send_vec("t5_bp", {16'hE000, 16'h2000}, lat);
        check("t5_latency", lat, 3);
        held = {16'h0800, 16'h1800};
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            data_in  = 32'(i) * 32'h0101_0101;
            step();
            check("t5_hold_valid", out_valid, 1'b1);
            check("t5_hold_data", data_out, held);
            check("t5_hold_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_release_ready", in_ready, 1'b1);
        check("t5_release_valid", out_valid, 1'b0);
        check("t5_release_busy", busy, 1'b0);

        // Reset on the first RUN cycle
        in_valid = 1'b1;
        data_in  = {16'h2000, 16'h1000};
        step();
        in_valid = 1'b0;
        check("t6_running", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_data_out", data_out, 32'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_in_ready", in_ready, 1'b1);
        repeat (4) begin
            step();
            check("t6_stays_idle", busy, 1'b0);
        end
        run_vec("t6_fresh", {16'h2000, 16'h1000}, {16'h1800, 16'h1400});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
